// File: rtl/series_det_ctrl.sv
// rtl/series_det_ctrl.sv - configurable serial series detector with start/fill/run/done sequencing
module series_det_ctrl #(
    parameter int LEN   = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [LEN-1:0]   cfg_pattern,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_limit,
    input  logic             start,
    input  logic             stop,
    input  logic             a,
    input  logic             in_valid,
    output logic             w,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int FW = (LEN > 2) ? $clog2(LEN) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [LEN-2:0]   hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [LEN-1:0]   pat_q, pat_d;
    logic             ovl_q, ovl_d;
    logic [CNT_W-1:0] lim_q, lim_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_q, w_d;

    logic [LEN-1:0]   window;
    logic             match;
    logic [CNT_W-1:0] cnt_inc;

    // window holds the candidate series including the bit arriving this cycle
    assign window    = {hist_q, a};
    assign match     = (window == pat_q);
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    assign cfg_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy      = (state_q == ST_FILL) || (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign w         = w_q;
    assign match_cnt = cnt_q;

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        ovl_d   = ovl_q;
        lim_d   = lim_q;
        cnt_d   = cnt_q;
        w_d     = 1'b0;

        if (cfg_valid && cfg_ready) begin
            pat_d = cfg_pattern;
            ovl_d = cfg_overlap;
            lim_d = cfg_limit;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                    hist_d  = '0;
                    fill_d  = '0;
                end
            end
            ST_FILL: begin
                if (in_valid) begin
                    hist_d = window[LEN-2:0];
                    fill_d = fill_q + 1'b1;
                    if (fill_q == FW'(LEN - 2))
                        state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    hist_d = window[LEN-2:0];
                    if (match) begin
                        w_d   = 1'b1;
                        cnt_d = cnt_inc;
                        if (!ovl_q) begin
                            hist_d  = '0;
                            fill_d  = '0;
                            state_d = ST_FILL;
                        end
                        if ((lim_q != '0) && (cnt_inc == lim_q))
                            state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // abort overrides start and discards any match seen this cycle
        if (stop) begin
            state_d = ST_IDLE;
            w_d     = 1'b0;
            cnt_d   = cnt_q;
            hist_d  = hist_q;
            fill_d  = fill_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= '0;
            ovl_q   <= 1'b1;
            lim_q   <= '0;
            cnt_q   <= '0;
            w_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
            lim_q   <= lim_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
        end
    end

endmodule

// File: tb/tb_series_det_ctrl.sv
// tb/tb_series_det_ctrl.sv - scoreboard bench for series_det_ctrl
module tb_series_det_ctrl;

    localparam int LEN   = 3;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [LEN-1:0]   cfg_pattern;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_limit;
    logic             start;
    logic             stop;
    logic             a;
    logic             in_valid;
    logic             w;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] match_cnt;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    series_det_ctrl #(.LEN(LEN), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap),
        .cfg_limit  (cfg_limit),
        .start      (start),
        .stop       (stop),
        .a          (a),
        .in_valid   (in_valid),
        .w          (w),
        .busy       (busy),
        .done       (done),
        .match_cnt  (match_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", tag, obs, exp);
        end
    endtask

    // one clock of stimulus; expected w for the following edge is queued and checked there
    task automatic step(input logic ai, input logic vi, input logic ew);
        a        = ai;
        in_valid = vi;
        exp_q.push_back(ew);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) check_val("scoreboard_empty", 1, 0);
        else check_val("w", {31'b0, w}, {31'b0, exp_q.pop_front()});
        a         = 1'b0;
        in_valid  = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic cfg_start(input logic [LEN-1:0] pat, input logic ovl, input logic [CNT_W-1:0] lim);
        cfg_valid   = 1'b1;
        cfg_pattern = pat;
        cfg_overlap = ovl;
        cfg_limit   = lim;
        start       = 1'b1;
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step(1'b0, 1'b0, 1'b0);
    endtask

    logic [4:0] s5;
    logic [6:0] s7;
    logic [6:0] e7;

    initial begin
        rst = 1'b0; cfg_valid = 0; cfg_pattern = '0; cfg_overlap = 0; cfg_limit = '0;
        start = 0; stop = 0; a = 0; in_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_w", {31'b0, w}, 0);
        check_val("rst_busy", {31'b0, busy}, 0);
        check_val("rst_done", {31'b0, done}, 0);
        check_val("rst_cnt", {24'b0, match_cnt}, 0);
        check_val("rst_cfg_ready", {31'b0, cfg_ready}, 1);
        rst = 1'b1;

        // overlapping: 1,0,1,0,1 matches at bits 3 and 5
        cfg_start(3'b101, 1'b1, 8'd0);
        check_val("ovl_busy_start", {31'b0, busy}, 1);
        s5 = 5'b10101;
        for (int i = 4; i >= 0; i--) step(s5[i], 1'b1, (i == 2) || (i == 0));
        step(1'b0, 1'b0, 1'b0);
        check_val("ovl_cnt", {24'b0, match_cnt}, 2);
        check_val("ovl_busy", {31'b0, busy}, 1);
        check_val("ovl_cfg_ready", {31'b0, cfg_ready}, 0);
        do_stop();
        check_val("stop_busy", {31'b0, busy}, 0);
        check_val("stop_cnt_held", {24'b0, match_cnt}, 2);

        // non-overlapping: history cleared after first match
        cfg_start(3'b101, 1'b0, 8'd0);
        check_val("novl_cnt_cleared", {24'b0, match_cnt}, 0);
        for (int i = 4; i >= 0; i--) step(s5[i], 1'b1, (i == 2));
        check_val("novl_cnt", {24'b0, match_cnt}, 1);
        check_val("novl_busy", {31'b0, busy}, 1);
        do_stop();

        // limit of 2: done after bit 5, bit 7 ignored
        cfg_start(3'b101, 1'b1, 8'd2);
        s7 = 7'b1010101;
        e7 = 7'b0010100;
        for (int i = 6; i >= 0; i--) begin
            step(s7[i], 1'b1, e7[i]);
            if (i == 2) check_val("lim_done_at_5", {31'b0, done}, 1);
        end
        check_val("lim_done", {31'b0, done}, 1);
        check_val("lim_cnt", {24'b0, match_cnt}, 2);
        check_val("lim_cfg_ready", {31'b0, cfg_ready}, 1);
        check_val("lim_busy", {31'b0, busy}, 0);

        // gaps are transparent; config write accepted from DONE
        cfg_start(3'b101, 1'b1, 8'd0);
        check_val("gap_done_cleared", {31'b0, done}, 0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check_val("gap_cnt", {24'b0, match_cnt}, 1);

        // config lockout in RUN: pattern 111 must not take effect
        cfg_valid   = 1'b1;
        cfg_pattern = 3'b111;
        cfg_overlap = 1'b1;
        cfg_limit   = 8'd0;
        #1;
        check_val("lock_cfg_ready", {31'b0, cfg_ready}, 0);
        step(1'b0, 1'b0, 1'b0);
        do_stop();
        start = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        check_val("lock_cnt", {24'b0, match_cnt}, 1);
        do_stop();

        // start+stop together in IDLE stays IDLE
        start = 1'b1;
        stop  = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check_val("prio_busy", {31'b0, busy}, 0);
        check_val("prio_cfg_ready", {31'b0, cfg_ready}, 1);

        // stop on a matching bit discards the pulse and holds the count
        start = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        stop = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        check_val("stopm_busy", {31'b0, busy}, 0);
        check_val("stopm_cnt", {24'b0, match_cnt}, 1);
        step(1'b0, 1'b0, 1'b0);

        // async reset mid-RUN with a match pending
        start = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        a        = 1'b1;
        in_valid = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_w", {31'b0, w}, 0);
        check_val("arst_cnt", {24'b0, match_cnt}, 0);
        check_val("arst_busy", {31'b0, busy}, 0);
        @(posedge clk);
        #1;
        check_val("arst_w_hold", {31'b0, w}, 0);
        a        = 1'b0;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        check_val("arst_cfg_ready", {31'b0, cfg_ready}, 1);
        check_val("arst_done", {31'b0, done}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
